uart_tx_arbiter: RTL and testbench

//  Shares the SOC's single serial output TXD between two byte producers (port 0: CPU store

---
 rtl/uart_tx_arbiter_pkg.sv | 14 +
 rtl/uart_tx_serializer.sv | 88 ++++++++
 rtl/uart_tx_arbiter.sv | 59 +++++
 tb/tb_uart_tx_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and state encoding for the two-port UART transmitter.
package uart_tx_arbiter_pkg;

  localparam logic        UartIdleLevel = 1'b1;
  localparam int unsigned UartDataBits  = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: a start strobe in idle latches the byte and shifts it out LSB-first.
module uart_tx_serializer
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [UartDataBits-1:0] data,
  output logic                    txd,
  output logic                    busy
);

  localparam int unsigned       CntW    = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0]   CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BitLast = 3'(UartDataBits - 1);

  tx_state_e               state_q;
  logic [CntW-1:0]         cnt_q;
  logic [2:0]              bit_q;
  logic [UartDataBits-1:0] shift_q;
  logic                    txd_q;
  logic                    bit_end;

  assign bit_end = (cnt_q == CntLast);
  assign txd     = txd_q;
  assign busy    = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= UartIdleLevel;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          bit_q <= '0;
          txd_q <= UartIdleLevel;
          if (start) begin
            shift_q <= data;
            txd_q   <= ~UartIdleLevel;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            cnt_q   <= '0;
            txd_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == BitLast) begin
              txd_q   <= UartIdleLevel;
              state_q <= StStop;
            end else begin
              // txd is registered, so the next bit is presented on the boundary edge
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte producers.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       txd,
  output logic       tx_busy,
  output logic       last_grant
);

  logic       last_grant_q;
  logic       grant0;
  logic       grant1;
  logic       xfer;
  logic [7:0] xfer_data;
  logic       ser_busy;

  // Under contention the port that did not win last time is served.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant_q);
    grant1 = req1_valid & (~req0_valid | ~last_grant_q);
  end

  assign req0_ready = ~reset & ~ser_busy & grant0;
  assign req1_ready = ~reset & ~ser_busy & grant1;
  assign xfer       = req0_ready | req1_ready;
  assign xfer_data  = req1_ready ? req1_data : req0_data;
  assign tx_busy    = ser_busy;
  assign last_grant = last_grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (xfer) begin
      last_grant_q <= req1_ready;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .clk  (clk),
    .reset(reset),
    .start(xfer),
    .data (xfer_data),
    .txd  (txd),
    .busy (ser_busy)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter against a frame-timing reference model.
module tb_uart_tx_arbiter;

  localparam int Cpb      = 4;
  localparam int FrameLen = 10 * Cpb;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic       req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic [7:0] req1_data = 8'h00;
  logic       req0_ready;
  logic       req1_ready;
  logic       txd;
  logic       tx_busy;
  logic       last_grant;

  uart_tx_arbiter #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .txd       (txd),
    .tx_busy   (tx_busy),
    .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: age counts clock edges since the accepting edge (1000 = no frame).
  int         age = 1000;
  bit         m_last = 1'b1;
  logic [7:0] m_byte = 8'h00;
  bit         g0, g1;
  int         prob0 = 0;
  int         prob1 = 0;
  int         cyc = 0;
  int         busy_cnt = 0;
  int         low_cnt = 0;
  int         rdy_port[$];
  int         rdy_cyc[$];

  function automatic bit exp_txd(input int a, input logic [7:0] b);
    int slot;
    if (a < 1 || a > FrameLen) return 1'b1;
    slot = (a - 1) / Cpb;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  task automatic step();
    bit busy_m;
    @(negedge clk);
    busy_m = (age >= 1 && age <= FrameLen);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset && !busy_m) begin
      if (req0_valid && req1_valid) begin
        g0 = m_last;
        g1 = !m_last;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
    check_eq("txd", txd, exp_txd(age, m_byte));
    check_eq("tx_busy", tx_busy, busy_m);
    check_eq("req0_ready", req0_ready, g0);
    check_eq("req1_ready", req1_ready, g1);
    check_eq("last_grant", last_grant, m_last);
    if (tx_busy === 1'b1) busy_cnt++;
    if (txd !== 1'b1) low_cnt++;
    if (req0_ready === 1'b1) begin rdy_port.push_back(0); rdy_cyc.push_back(cyc); end
    if (req1_ready === 1'b1) begin rdy_port.push_back(1); rdy_cyc.push_back(cyc); end
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      age    = 1000;
      m_last = 1'b1;
    end else if (g0 || g1) begin
      age    = 1;
      m_last = g1;
      m_byte = g1 ? req1_data : req0_data;
    end else if (age < 1000) begin
      age++;
    end
    if (g0) req0_valid = 1'b0;
    if (g1) req1_valid = 1'b0;
    if (!req0_valid && $urandom_range(99) < prob0) begin
      req0_valid = 1'b1;
      req0_data  = 8'($urandom);
    end
    if (!req1_valid && $urandom_range(99) < prob1) begin
      req1_valid = 1'b1;
      req1_data  = 8'($urandom);
    end
  endtask

  task automatic clear_log();
    rdy_port.delete();
    rdy_cyc.delete();
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step();
    reset = 1'b0;

    // Single request from port 0
    busy_cnt = 0;
    clear_log();
    req0_valid = 1'b1;
    req0_data  = 8'hA5;
    repeat (50) step();
    check_eq("t2_busy_len", busy_cnt, 40);
    check_eq("t2_accepts", rdy_port.size(), 1);
    check_eq("t2_last_grant", last_grant, 0);

    // Simultaneous requests right after reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_log();
    req0_valid = 1'b1;
    req0_data  = 8'h55;
    req1_valid = 1'b1;
    req1_data  = 8'h0F;
    repeat (90) step();
    check_eq("t3_accepts", rdy_port.size(), 2);
    if (rdy_port.size() >= 2) begin
      check_eq("t3_first", rdy_port[0], 0);
      check_eq("t3_second", rdy_port[1], 1);
      check_eq("t3_gap", rdy_cyc[1] - rdy_cyc[0], FrameLen + 1);
    end

    // Both ports continuously valid
    clear_log();
    prob0 = 100;
    prob1 = 100;
    req0_valid = 1'b1;
    req0_data  = 8'($urandom);
    req1_valid = 1'b1;
    req1_data  = 8'($urandom);
    repeat (4 * (FrameLen + 1) + 2) step();
    for (int i = 0; i < 4; i++) begin
      check_eq("t4_order", (i < rdy_port.size()) ? rdy_port[i] : 99, i % 2);
    end
    prob0 = 0;
    prob1 = 0;
    repeat (130) step();

    // Port 1 streaming, port 0 joins mid-frame
    clear_log();
    prob1 = 100;
    req1_valid = 1'b1;
    req1_data  = 8'($urandom);
    repeat (20) step();
    req0_valid = 1'b1;
    req0_data  = 8'($urandom);
    repeat (130) step();
    for (int i = 0; i < 3; i++) begin
      check_eq("t5_order", (i < rdy_port.size()) ? rdy_port[i] : 99, (i == 1) ? 0 : 1);
    end
    prob1 = 0;
    repeat (130) step();

    // Reset in the middle of a frame
    req0_valid = 1'b1;
    req0_data  = 8'($urandom);
    repeat (16) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    low_cnt  = 0;
    busy_cnt = 0;
    repeat (50) step();
    check_eq("t6_txd_low", low_cnt, 0);
    check_eq("t6_busy", busy_cnt, 0);

    // Random traffic with occasional resets
    for (int blk = 0; blk < 15; blk++) begin
      prob0 = int'($urandom_range(100));
      prob1 = int'($urandom_range(100));
      repeat (200) begin
        reset = ($urandom_range(399) == 0);
        step();
      end
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
